// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: per-axis region FSMs, registered pixel/sync/blank/strobe outputs.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 800,
    parameter int H_FRONT    = 56,
    parameter int H_SYNC     = 120,
    parameter int H_BACK     = 64,
    parameter int V_VISIBLE  = 600,
    parameter int V_FRONT    = 37,
    parameter int V_SYNC     = 6,
    parameter int V_BACK     = 23,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1,
    parameter int PIX_DIV    = 1,
    parameter int X_WIDTH    = 11,
    parameter int Y_WIDTH    = 10
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic               pixelEn,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               blank_n,
    output logic               hSync,
    output logic               vSync,
    output logic               sync_n,
    output logic               lineStart,
    output logic               frameStart
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [15:0]        frameCount
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    generate
        if (H_TOTAL - 1 >= (1 << X_WIDTH)) begin : g_x_width_check
            $error("vga_timing_gen: X_WIDTH cannot hold H_TOTAL-1");
        end
        if (V_TOTAL - 1 >= (1 << Y_WIDTH)) begin : g_y_width_check
            $error("vga_timing_gen: Y_WIDTH cannot hold V_TOTAL-1");
        end
        if (PIX_DIV < 1) begin : g_div_check
            $error("vga_timing_gen: PIX_DIV must be at least 1");
        end
        if (H_VISIBLE < 1 || V_VISIBLE < 1) begin : g_visible_check
            $error("vga_timing_gen: visible regions must be non-empty");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_VISIBLE = 2'd0,
        ST_FRONT   = 2'd1,
        ST_SYNC    = 2'd2,
        ST_BACK    = 2'd3
    } region_t;

    function automatic int region_len(input logic vert, input region_t r);
        int len;
        len = 0;
        case (r)
            ST_VISIBLE: len = vert ? V_VISIBLE : H_VISIBLE;
            ST_FRONT:   len = vert ? V_FRONT   : H_FRONT;
            ST_SYNC:    len = vert ? V_SYNC    : H_SYNC;
            ST_BACK:    len = vert ? V_BACK    : H_BACK;
            default:    len = 0;
        endcase
        return len;
    endfunction

    // Next region in ring order, stepping over any zero-length region.
    function automatic region_t next_region(input logic vert, input region_t r);
        region_t    nr;
        logic       found;
        logic [1:0] idx;
        nr    = r;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = 2'(r) + 2'(i);
            if (!found && region_len(vert, region_t'(idx)) != 0) begin
                nr    = region_t'(idx);
                found = 1'b1;
            end
        end
        return nr;
    endfunction

    logic [DIV_W-1:0]   div_reg, div_next;
    logic               pixel_en_reg, pixel_en_next;
    region_t            h_state_reg, h_state_next;
    region_t            v_state_reg, v_state_next;
    logic [X_WIDTH-1:0] h_cnt_reg, h_cnt_next, x_reg, x_next;
    logic [Y_WIDTH-1:0] v_cnt_reg, v_cnt_next, y_reg, y_next;
    logic               h_end, v_end, x_wrap, y_wrap, line_adv, frame_adv;
    logic               blank_n_reg, h_sync_reg, v_sync_reg, sync_n_reg;
    logic               line_start_reg, frame_start_reg;

    always_comb begin
        div_next      = div_reg;
        pixel_en_next = pixel_en_reg;
        h_state_next  = h_state_reg;
        h_cnt_next    = h_cnt_reg;
        x_next        = x_reg;
        v_state_next  = v_state_reg;
        v_cnt_next    = v_cnt_reg;
        y_next        = y_reg;

        h_end     = (h_cnt_reg == X_WIDTH'(region_len(1'b0, h_state_reg) - 1));
        v_end     = (v_cnt_reg == Y_WIDTH'(region_len(1'b1, v_state_reg) - 1));
        x_wrap    = (x_reg == X_WIDTH'(H_TOTAL - 1));
        y_wrap    = (y_reg == Y_WIDTH'(V_TOTAL - 1));
        line_adv  = pixel_en_reg && x_wrap;
        frame_adv = line_adv && y_wrap;

        // pixel_en_reg is high exactly while the divider sits at PIX_DIV-1
        div_next      = pixel_en_reg ? '0 : div_reg + DIV_W'(1);
        pixel_en_next = (div_next == DIV_W'(PIX_DIV - 1));

        if (pixel_en_reg) begin
            x_next = x_wrap ? '0 : x_reg + X_WIDTH'(1);
            if (h_end) begin
                h_state_next = next_region(1'b0, h_state_reg);
                h_cnt_next   = '0;
            end else begin
                h_cnt_next   = h_cnt_reg + X_WIDTH'(1);
            end
        end

        if (line_adv) begin
            y_next = y_wrap ? '0 : y_reg + Y_WIDTH'(1);
            if (v_end) begin
                v_state_next = next_region(1'b1, v_state_reg);
                v_cnt_next   = '0;
            end else begin
                v_cnt_next   = v_cnt_reg + Y_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            div_reg         <= '0;
            pixel_en_reg    <= (PIX_DIV == 1);
            h_state_reg     <= ST_VISIBLE;
            h_cnt_reg       <= '0;
            x_reg           <= '0;
            v_state_reg     <= ST_VISIBLE;
            v_cnt_reg       <= '0;
            y_reg           <= '0;
            blank_n_reg     <= 1'b1;
            h_sync_reg      <= ~H_SYNC_POL;
            v_sync_reg      <= ~V_SYNC_POL;
            sync_n_reg      <= 1'b1;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            div_reg         <= div_next;
            pixel_en_reg    <= pixel_en_next;
            h_state_reg     <= h_state_next;
            h_cnt_reg       <= h_cnt_next;
            x_reg           <= x_next;
            v_state_reg     <= v_state_next;
            v_cnt_reg       <= v_cnt_next;
            y_reg           <= y_next;
            // Decoded from the next FSM states so the flags line up with the new x/y
            blank_n_reg     <= (h_state_next == ST_VISIBLE) && (v_state_next == ST_VISIBLE);
            h_sync_reg      <= (h_state_next == ST_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
            v_sync_reg      <= (v_state_next == ST_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
            sync_n_reg      <= !((h_state_next == ST_SYNC) || (v_state_next == ST_SYNC));
            line_start_reg  <= line_adv;
            frame_start_reg <= frame_adv;
        end
    end

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] frame_count_reg;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            frame_count_reg <= '0;
        end else if (frame_adv) begin
            frame_count_reg <= frame_count_reg + 16'd1;
        end
    end

    assign frameCount = frame_count_reg;
`endif

    assign pixelEn    = pixel_en_reg;
    assign x          = x_reg;
    assign y          = y_reg;
    assign blank_n    = blank_n_reg;
    assign hSync      = h_sync_reg;
    assign vSync      = v_sync_reg;
    assign sync_n     = sync_n_reg;
    assign lineStart  = line_start_reg;
    assign frameStart = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: vector table, corner sequences and a raster-arithmetic reference model
// checked every clock on three instances (small mode, small mode with PIX_DIV=3 and inverted polarity, default 800x600).
module tb_vga_timing_gen;

    logic clk;
    logic rst_a, rst_b, rst_c;

    logic       a_pe, a_b, a_hs, a_vs, a_sn, a_ls, a_fs;
    logic [3:0] a_x;
    logic [2:0] a_y;
    logic       b_pe, b_b, b_hs, b_vs, b_sn, b_ls, b_fs;
    logic [3:0] b_x;
    logic [2:0] b_y;
    logic        c_pe, c_b, c_hs, c_vs, c_sn, c_ls, c_fs;
    logic [10:0] c_x;
    logic [9:0]  c_y;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] a_fc, b_fc, c_fc;
`endif

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIX_DIV(1), .X_WIDTH(4), .Y_WIDTH(3)
    ) u_a (
        .Clock(clk), .Reset(rst_a), .pixelEn(a_pe), .x(a_x), .y(a_y), .blank_n(a_b),
        .hSync(a_hs), .vSync(a_vs), .sync_n(a_sn), .lineStart(a_ls), .frameStart(a_fs)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frameCount(a_fc)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIX_DIV(3), .X_WIDTH(4), .Y_WIDTH(3)
    ) u_b (
        .Clock(clk), .Reset(rst_b), .pixelEn(b_pe), .x(b_x), .y(b_y), .blank_n(b_b),
        .hSync(b_hs), .vSync(b_vs), .sync_n(b_sn), .lineStart(b_ls), .frameStart(b_fs)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frameCount(b_fc)
`endif
    );

    vga_timing_gen u_c (
        .Clock(clk), .Reset(rst_c), .pixelEn(c_pe), .x(c_x), .y(c_y), .blank_n(c_b),
        .hSync(c_hs), .vSync(c_vs), .sync_n(c_sn), .lineStart(c_ls), .frameStart(c_fs)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frameCount(c_fc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] fc;
        logic [15:0] x;
        logic [15:0] y;
        logic        pe, b, hs, vs, sn, ls, fs;
    } obs_t;

    typedef struct packed {
        int   n;
        int   x;
        int   y;
        logic b, hs, vs, ls, fs;
    } vec_t;

    int n_checks, n_fail;
    int n_a, n_b, n_c;
    bit va, vb, vc;

    // Expected outputs n clocks after reset, from raster arithmetic only.
    function automatic obs_t model(input int n, input int hv, input int hf, input int hsl, input int hb,
                                   input int vv, input int vf, input int vsl, input int vb_,
                                   input bit hp, input bit vp, input int div);
        obs_t m;
        int ht, vt, p, pos, xx, yy;
        bit hin, vin, edge_n;
        ht  = hv + hf + hsl + hb;
        vt  = vv + vf + vsl + vb_;
        p   = n / div;
        pos = p % (ht * vt);
        xx  = pos % ht;
        yy  = pos / ht;
        hin = (xx >= hv + hf) && (xx < hv + hf + hsl);
        vin = (yy >= vv + vf) && (yy < vv + vf + vsl);
        edge_n = (n > 0) && (n % div == 0);
        m.x  = 16'(xx);
        m.y  = 16'(yy);
        m.pe = ((n % div) == div - 1);
        m.b  = (xx < hv) && (yy < vv);
        m.hs = hin ? hp : !hp;
        m.vs = vin ? vp : !vp;
        m.sn = !(hin || vin);
        m.ls = edge_n && (xx == 0);
        m.fs = edge_n && (pos == 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        m.fc = 16'(p / (ht * vt));
`else
        m.fc = 16'd0;
`endif
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_obs(input string name, input int n, input obs_t g, input obs_t e);
        n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s n=%0d: actual x=%0d y=%0d pe,b,hs,vs,sn,ls,fs=%b%b%b%b%b%b%b fc=%0d required x=%0d y=%0d pe,b,hs,vs,sn,ls,fs=%b%b%b%b%b%b%b fc=%0d",
                     name, n, g.x, g.y, g.pe, g.b, g.hs, g.vs, g.sn, g.ls, g.fs, g.fc,
                     e.x, e.y, e.pe, e.b, e.hs, e.vs, e.sn, e.ls, e.fs, e.fc);
        end
    endtask

    // One clock: track cycles since reset per instance, then compare every instance with the model.
    task automatic tick();
        obs_t g;
        @(posedge clk);
        if (rst_a) begin n_a = 0; va = 1'b1; end else n_a++;
        if (rst_b) begin n_b = 0; vb = 1'b1; end else n_b++;
        if (rst_c) begin n_c = 0; vc = 1'b1; end else n_c++;
        @(negedge clk);
        if (va) begin
            g = '{fc: 16'd0, x: 16'(a_x), y: 16'(a_y), pe: a_pe, b: a_b, hs: a_hs, vs: a_vs, sn: a_sn, ls: a_ls, fs: a_fs};
`ifdef VGA_TIMING_FRAME_COUNT_EN
            g.fc = a_fc;
`endif
            chk_obs("model_a", n_a, g, model(n_a, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 1));
        end
        if (vb) begin
            g = '{fc: 16'd0, x: 16'(b_x), y: 16'(b_y), pe: b_pe, b: b_b, hs: b_hs, vs: b_vs, sn: b_sn, ls: b_ls, fs: b_fs};
`ifdef VGA_TIMING_FRAME_COUNT_EN
            g.fc = b_fc;
`endif
            chk_obs("model_b", n_b, g, model(n_b, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0, 3));
        end
        if (vc) begin
            g = '{fc: 16'd0, x: 16'(c_x), y: 16'(c_y), pe: c_pe, b: c_b, hs: c_hs, vs: c_vs, sn: c_sn, ls: c_ls, fs: c_fs};
`ifdef VGA_TIMING_FRAME_COUNT_EN
            g.fc = c_fc;
`endif
            chk_obs("model_c", n_c, g, model(n_c, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1, 1));
        end
    endtask

    task automatic reset_a(); rst_a = 1'b1; tick(); rst_a = 1'b0; endtask
    task automatic reset_b(); rst_b = 1'b1; tick(); rst_b = 1'b0; endtask
    task automatic reset_c(); rst_c = 1'b1; tick(); rst_c = 1'b0; endtask

    vec_t tbl [0:15];

    initial begin
        int cur, cnt, cnt2, first_x, last_x;
        logic [3:0] xv;

        // n, x, y, blank_n, hSync, vSync, lineStart, frameStart for the small active-high mode
        tbl[0]  = '{0,  0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{3,  3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{4,  4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{5,  5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{6,  6, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{7,  7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{8,  0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{19, 3, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{24, 0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{29, 5, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{32, 0, 4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{38, 6, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{40, 0, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{47, 7, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{48, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{49, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        n_checks = 0; n_fail = 0;
        n_a = 0; n_b = 0; n_c = 0;
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        tick();
        tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        reset_a();
        cur = 0;
        for (int i = 0; i < 16; i++) begin
            while (cur < tbl[i].n) begin tick(); cur++; end
            chk($sformatf("tbl%0d_xy", i), {16'(a_x), 16'(a_y)}, {16'(tbl[i].x), 16'(tbl[i].y)});
            chk($sformatf("tbl%0d_flags", i), {27'd0, a_b, a_hs, a_vs, a_ls, a_fs},
                {27'd0, tbl[i].b, tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs});
        end

        // Reset at (6,4): immediate return to origin, no strobe, full frame before the next frameStart
        reset_a();
        repeat (38) tick();
        chk("pre_reset_xy", {16'(a_x), 16'(a_y)}, {16'd6, 16'd4});
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        chk("post_reset_xy", {16'(a_x), 16'(a_y)}, 32'd0);
        chk("post_reset_flags", {29'd0, a_b, a_fs, a_ls}, {29'd0, 1'b1, 1'b0, 1'b0});
        cnt = 0;
        do begin tick(); cnt++; end while (!a_fs && cnt < 100);
        chk("restart_frame_clocks", cnt, 48);

        // PIX_DIV=3: pixelEn cadence, x hold time, strobe width, frame period
        reset_b();
        cnt = 0;
        repeat (12) begin tick(); if (b_pe) cnt++; end
        chk("b_pixel_en_count", cnt, 4);
        reset_b();
        cnt = 0;
        while (b_x == 4'd0 && cnt < 20) begin tick(); cnt++; end
        xv = b_x; cnt2 = 0;
        while (b_x == xv && cnt2 < 20) begin tick(); cnt2++; end
        chk("b_x_hold", cnt2, 3);
        cnt = 0;
        while (!b_ls && cnt < 100) begin tick(); cnt++; end
        chk("b_line_start_seen", b_ls, 1);
        tick();
        chk("b_line_start_width", b_ls, 0);
        cnt = 0;
        while (!b_fs && cnt < 400) begin tick(); cnt++; end
        chk("b_frame_start_seen", b_fs, 1);
        cnt = 0;
        do begin tick(); cnt++; end while (!b_fs && cnt < 400);
        chk("b_frame_period", cnt, 144);

        // Default 800x600: horizontal sync window on the first line
        reset_c();
        first_x = -1; last_x = -1; cnt = 0;
        for (int i = 0; i < 1040; i++) begin
            tick();
            if (c_hs) begin
                if (first_x < 0) first_x = int'(c_x);
                last_x = int'(c_x);
                cnt++;
            end
        end
        chk("c_hsync_first_x", first_x, 856);
        chk("c_hsync_last_x", last_x, 975);
        chk("c_hsync_width", cnt, 120);

`ifdef VGA_TIMING_FRAME_COUNT_EN
        reset_a();
        for (int f = 1; f <= 3; f++) begin
            cnt = 0;
            do begin tick(); cnt++; end while (!a_fs && cnt < 100);
            chk($sformatf("fc_frame%0d_clocks", f), cnt, 48);
            chk($sformatf("fc_frame%0d_value", f), 32'(a_fc), f);
        end
`endif

        // Random reset pulses; the per-clock model comparison does the checking
        for (int i = 0; i < 3000; i++) begin
            rst_a = ($urandom_range(0, 199) == 0);
            rst_b = ($urandom_range(0, 299) == 0);
            rst_c = ($urandom_range(0, 2999) == 0);
            tick();
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
